// File: rtl/pc_pkg.sv
// Shared encodings for the PC controller: FSM states, next-PC selects, cause codes.
package pc_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_J   = 2'b10,
    SEL_JR  = 2'b11
  } sel_e;

  localparam logic [4:0] CAUSE_ADEL = 5'd4;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC source select; redirect targets are word-aligned and
// a misalignment flag is raised for the caller to act on.
module pc_next
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] pc_plus,
  input  logic [WIDTH-1:0] br_target,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] next_pc,
  output logic             misaligned
);

  always_comb begin
    next_pc    = pc_plus;
    misaligned = 1'b0;
    case (sel_e'(sel))
      SEL_SEQ: next_pc = pc_plus;
      SEL_BR: begin
        next_pc    = {br_target[WIDTH-1:2], 2'b00};
        misaligned = |br_target[1:0];
      end
      SEL_J:   next_pc = {pc_plus[WIDTH-1:28], j_index, 2'b00};
      SEL_JR: begin
        next_pc    = {jr_target[WIDTH-1:2], 2'b00};
        misaligned = |jr_target[1:0];
      end
      default: next_pc = pc_plus;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// PC register, exception EPC/cause capture and RUN/HANDLER FSM; updates on the
// falling clock edge. Define PC_ALIGN_CHECK_EN to trap misaligned redirects.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h00400000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h00400004,
  parameter int unsigned      STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] br_target,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  input  logic [4:0]       exc_cause,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic [4:0]       cause,
  output logic             in_exc,
  output logic [WIDTH-1:0] adv_cnt
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_e           state, state_n;
  logic [WIDTH-1:0] pc_n, epc_n, cnt_n, next_pc;
  logic [4:0]       cause_n;
  logic             misaligned;

  assign pc_plus = pc + WIDTH'(STEP);
  assign in_exc  = (state == HANDLER);

  pc_next #(.WIDTH(WIDTH)) u_pc_next (
    .sel        (sel),
    .pc_plus    (pc_plus),
    .br_target  (br_target),
    .j_index    (j_index),
    .jr_target  (jr_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // A real exc_req outranks the misalignment trap, so its cause wins.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    epc_n   = epc;
    cause_n = cause;
    cnt_n   = adv_cnt;
    if (ena) begin
      if (state == RUN && exc_req) begin
        epc_n   = pc;
        cause_n = exc_cause;
        pc_n    = EXC_VEC;
        state_n = HANDLER;
        cnt_n   = adv_cnt + 1'b1;
      end else if (state == HANDLER && eret) begin
        pc_n    = epc;
        state_n = RUN;
        cnt_n   = adv_cnt + 1'b1;
      end else if (!stall) begin
        if (state == RUN && ALIGN_CHECK && misaligned) begin
          epc_n   = pc;
          cause_n = CAUSE_ADEL;
          pc_n    = EXC_VEC;
          state_n = HANDLER;
        end else begin
          pc_n = next_pc;
        end
        cnt_n = adv_cnt + 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_VEC;
      epc     <= '0;
      cause   <= '0;
      adv_cnt <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      epc     <= epc_n;
      cause   <= cause_n;
      adv_cnt <= cnt_n;
    end
  end

endmodule
